// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the RISC-V instruction fetch stage: FSM state codes,
// reset constants and instruction field positions.
package riscv_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_FAULT = 2'd3;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/riscv_next_pc.sv
// Combinational next-PC select (jal > jalr > taken branch > pc+4) and alignment
// check. FETCH_MISALIGN_TRAP_EN keeps the raw target and flags misalignment.
module riscv_next_pc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jal_en,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] sel;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    sel = pc_plus4;
    if (jump && jal_en) begin
      sel = jal_target;
    end else if (jump) begin
      sel = jalr_target & ~{{(XLEN-1){1'b0}}, 1'b1};
    end else if (branch && branch_taken) begin
      sel = branch_target;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc    = sel;
  assign misaligned = |sel[1:0];
`else
  assign next_pc    = sel & {{(XLEN-2){1'b1}}, 2'b00};
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/riscv_fetch_unit.sv
// RISC-V instruction fetch stage: PC register, IMEM request handshake and
// held instruction for the decoder. Optional macro: FETCH_MISALIGN_TRAP_EN.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jal_en,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            fetch_fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  assign pc_plus4 = pc + XLEN'(4);

  riscv_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc_plus4      (pc_plus4),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .jal_en        (jal_en),
    .branch_target (branch_target),
    .jal_target    (jal_target),
    .jalr_target   (jalr_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC[XLEN-1:0];
      instr <= NOP_INSTR;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Branch/jump controls are only meaningful on the accepting edge.
          if (instr_ready) begin
            if (misaligned) begin
              state <= ST_FAULT;
            end else begin
              pc    <= next_pc;
              state <= ST_REQ;
            end
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_HOLD);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = (state == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  assign opcode = instr[OPCODE_LSB +: 7];
  assign rd     = instr[RD_LSB     +: 5];
  assign funct3 = instr[FUNCT3_LSB +: 3];
  assign rs1    = instr[RS1_LSB    +: 5];
  assign rs2    = instr[RS2_LSB    +: 5];
  assign funct7 = instr[FUNCT7_LSB +: 7];

endmodule
